chirp_cmd_parser: RTL and testbench

Upstream command stage for the chirp generator. Consumes received bytes from the UART RX stage and validates 5-byte command frames (sync, SF, BW, symbol, checksum). On a valid frame it latches the chirp configuration and pulses a start strobe to the generator. It then holds off new commands until the generator reports completion through its active-low done line.

---
 rtl/chirp_pkg.sv | 27 ++
 rtl/chirp_cmd_parser.sv | 143 ++++++++++++++
 tb/tb_chirp_cmd_parser.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/chirp_pkg.sv
// Shared types and constants for the chirp command parser: FSM states,
// error codes and frame defaults.
package chirp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_SF,
    GET_BW,
    GET_SYM,
    GET_CHK,
    ISSUE,
    WAIT_RUN,
    WAIT_DONE
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_CHK     = 3'd1;
  localparam logic [2:0] ERR_RANGE   = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_FRAMING = 3'd4;
  localparam logic [2:0] ERR_BUSY    = 3'd5;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         MIN_SF_DEFAULT    = 5;
  localparam int         FRAME_LEN         = 5;

endpackage

// File: rtl/chirp_cmd_parser.sv
// Validates 5-byte UART command frames, latches the chirp configuration and
// starts the generator, then blocks new commands until the generator is done.
module chirp_cmd_parser
  import chirp_pkg::*;
#(
  parameter int                    MAX_SF_WIDTH   = 8,
  parameter int                    MIN_SF         = MIN_SF_DEFAULT,
  parameter int                    BW_BITWIDTH    = 2,
  parameter int                    DATA_WIDTH     = 8,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE      = DATA_WIDTH'(SYNC_BYTE_DEFAULT),
  parameter int                    TIMEOUT_CYCLES = 31250
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_rx_valid,
  input  logic [DATA_WIDTH-1:0]   i_rx_data,
  input  logic                    i_rx_err,
  input  logic                    i_done_n,
  output logic                    o_start,
  output logic [3:0]              o_sf,
  output logic [BW_BITWIDTH-1:0]  o_bw,
  output logic [MAX_SF_WIDTH-1:0] o_symbol,
  output logic                    o_busy,
  output logic                    o_err,
  output logic [2:0]              o_err_code
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] sf_byte, bw_byte, sym_byte, chk_acc;
  logic [CNT_W-1:0]      to_cnt;
  logic                  byte_ok, in_get, busy_state, timeout_hit;
  logic                  err_evt, cfg_load;
  logic [2:0]            err_code_nxt, frame_code;

  // Checks are ordered so a corrupted frame reports checksum before range.
  function automatic logic [2:0] frame_check(input logic [DATA_WIDTH-1:0] chk, acc, sf, bw, sym);
    if (chk != acc)                                                          return ERR_CHK;
    if (sf < DATA_WIDTH'(MIN_SF) || sf > DATA_WIDTH'(MAX_SF_WIDTH))          return ERR_RANGE;
    if ((bw >> BW_BITWIDTH) != '0)                                           return ERR_RANGE;
    if ((sym >> sf) != '0)                                                   return ERR_RANGE;
    return ERR_NONE;
  endfunction

  assign byte_ok     = i_rx_valid & ~i_rx_err;
  assign in_get      = state inside {GET_SF, GET_BW, GET_SYM, GET_CHK};
  assign busy_state  = state inside {ISSUE, WAIT_RUN, WAIT_DONE};
  assign timeout_hit = in_get && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign frame_code  = frame_check(i_rx_data, chk_acc, sf_byte, bw_byte, sym_byte);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (byte_ok && i_rx_data == SYNC_BYTE) state_nxt = GET_SF;
      GET_SF, GET_BW, GET_SYM, GET_CHK: begin
        if (i_rx_err || (!i_rx_valid && timeout_hit)) state_nxt = IDLE;
        else if (i_rx_valid) begin
          if      (state == GET_SF)  state_nxt = GET_BW;
          else if (state == GET_BW)  state_nxt = GET_SYM;
          else if (state == GET_SYM) state_nxt = GET_CHK;
          else                       state_nxt = (frame_code == ERR_NONE) ? ISSUE : IDLE;
        end
      end
      ISSUE:     state_nxt = WAIT_RUN;
      WAIT_RUN:  if (i_done_n)  state_nxt = WAIT_DONE;
      WAIT_DONE: if (!i_done_n) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // A framing error beats a byte in the same cycle; a byte beats the timeout.
  always_comb begin
    o_start      = (state == ISSUE);
    o_busy       = busy_state;
    err_evt      = 1'b0;
    err_code_nxt = ERR_NONE;
    cfg_load     = 1'b0;
    if (in_get) begin
      if (i_rx_err) begin
        err_evt      = 1'b1;
        err_code_nxt = ERR_FRAMING;
      end else if (i_rx_valid) begin
        if (state == GET_CHK) begin
          if (frame_code != ERR_NONE) begin
            err_evt      = 1'b1;
            err_code_nxt = frame_code;
          end else begin
            cfg_load = 1'b1;
          end
        end
      end else if (timeout_hit) begin
        err_evt      = 1'b1;
        err_code_nxt = ERR_TIMEOUT;
      end
    end else if (busy_state && i_rx_valid) begin
      err_evt      = 1'b1;
      err_code_nxt = ERR_BUSY;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                      to_cnt <= '0;
    else if (in_get && !i_rx_valid && !i_rx_err && !timeout_hit) to_cnt <= to_cnt + 1'b1;
    else                               to_cnt <= '0;
  end

  always_ff @(posedge i_clk) begin
    if (byte_ok) begin
      case (state)
        IDLE:    chk_acc <= '0;
        GET_SF:  begin sf_byte  <= i_rx_data; chk_acc <= chk_acc ^ i_rx_data; end
        GET_BW:  begin bw_byte  <= i_rx_data; chk_acc <= chk_acc ^ i_rx_data; end
        GET_SYM: begin sym_byte <= i_rx_data; chk_acc <= chk_acc ^ i_rx_data; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sf       <= '0;
      o_bw       <= '0;
      o_symbol   <= '0;
      o_err      <= 1'b0;
      o_err_code <= ERR_NONE;
    end else begin
      o_err <= err_evt;
      if (err_evt) o_err_code <= err_code_nxt;
      if (cfg_load) begin
        o_sf     <= sf_byte[3:0];
        o_bw     <= bw_byte[BW_BITWIDTH-1:0];
        o_symbol <= sym_byte[MAX_SF_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_chirp_cmd_parser.sv
// Scoreboard bench for chirp_cmd_parser: directed frames plus randomized frames
// judged by a frame-level reference model.
module tb_chirp_cmd_parser;

  localparam int T = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx_valid = 1'b0, rx_err = 1'b0, done_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       o_start, o_busy, o_err;
  logic [3:0] o_sf;
  logic [1:0] o_bw;
  logic [7:0] o_symbol;
  logic [2:0] o_err_code;

  chirp_cmd_parser #(.TIMEOUT_CYCLES(T)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
    .i_rx_err(rx_err), .i_done_n(done_n), .o_start(o_start), .o_sf(o_sf),
    .o_bw(o_bw), .o_symbol(o_symbol), .o_busy(o_busy), .o_err(o_err),
    .o_err_code(o_err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;

  typedef struct {
    bit         is_err;
    logic [2:0] code;
    logic [7:0] sf, bw, sym;
    int         at;
  } exp_t;
  exp_t q[$];

  logic [7:0] m_sf = 0, m_bw = 0, m_sym = 0;
  logic [2:0] m_code = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Frame outcome straight from the command rules.
  function automatic logic [2:0] classify(input logic [7:0] sf, bw, sym, chk);
    if (chk != (sf ^ bw ^ sym))  return 3'd1;
    if (sf < 5 || sf > 8)        return 3'd2;
    if (bw > 3)                  return 3'd2;
    if (int'(sym) >= (1 << sf))  return 3'd2;
    return 3'd0;
  endfunction

  task automatic pop_check(input bit is_err);
    exp_t e;
    if (q.size() == 0) begin
      check(is_err ? "unexpected_err" : "unexpected_start", q.size(), 1);
      return;
    end
    e = q.pop_front();
    check("event_kind", is_err, e.is_err);
    check("event_cycle", cyc, e.at);
    if (is_err) begin
      check("err_code", o_err_code, e.code);
    end else begin
      check("start_sf", {4'h0, o_sf}, e.sf);
      check("start_bw", {6'h0, o_bw}, e.bw);
      check("start_sym", o_symbol, e.sym);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_start) pop_check(1'b0);
      if (o_err)   pop_check(1'b1);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit has_exp, input exp_t e, input int lat);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    if (has_exp) begin
      e.at = cyc + lat;
      q.push_back(e);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_rxerr(input bit with_valid, input logic [7:0] b, input bit has_exp, input exp_t e);
    @(negedge clk);
    rx_data  = b;
    rx_valid = with_valid;
    rx_err   = 1'b1;
    if (has_exp) begin
      e.at = cyc + 1;
      q.push_back(e);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_err   = 1'b0;
  endtask

  function automatic exp_t err_exp(input logic [2:0] code);
    exp_t e;
    e = '{is_err: 1'b1, code: code, sf: 0, bw: 0, sym: 0, at: 0};
    return e;
  endfunction

  task automatic run_frame(input logic [7:0] sf, bw, sym, chk, output bit passed);
    logic [7:0] bytes [chirp_pkg::FRAME_LEN];
    logic [2:0] code;
    exp_t       e, none;
    none  = err_exp(3'd0);
    bytes = '{8'hA5, sf, bw, sym, chk};
    code  = classify(sf, bw, sym, chk);
    e     = (code == 0) ? '{is_err: 1'b0, code: 3'd0, sf: sf, bw: bw, sym: sym, at: 0} : err_exp(code);
    for (int i = 0; i < chirp_pkg::FRAME_LEN - 1; i++) begin
      send(bytes[i], 1'b0, none, 0);
      idle($urandom_range(0, 3));
    end
    send(bytes[chirp_pkg::FRAME_LEN-1], 1'b1, e, 1);
    passed = (code == 0);
    if (passed) begin
      m_sf = sf; m_bw = bw; m_sym = sym;
    end else begin
      m_code = code;
      idle(2);
      check("cfg_held_sf", {4'h0, o_sf}, m_sf);
      check("cfg_held_sym", o_symbol, m_sym);
      check("err_code_held", o_err_code, m_code);
    end
  endtask

  task automatic handshake(input int run_len, input bit drop);
    exp_t none;
    none = err_exp(3'd0);
    idle(3);
    check("busy_ignores_low_done", o_busy, 1);
    if (drop) begin
      send(8'hA5, 1'b1, err_exp(3'd5), 1);
      m_code = 3'd5;
      idle(1);
      check("drop_cfg_sf", {4'h0, o_sf}, m_sf);
      check("drop_cfg_bw", {6'h0, o_bw}, m_bw);
      check("drop_cfg_sym", o_symbol, m_sym);
    end
    done_n = 1'b1;
    idle(run_len);
    check("busy_while_running", o_busy, 1);
    done_n = 1'b0;
    @(negedge clk);
    check("busy_falls", o_busy, 0);
    if (none.is_err) idle(1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"}, o_start, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_err"}, o_err, 0);
    check({tag, "_code"}, o_err_code, 0);
    check({tag, "_cfg"}, {o_sf, o_bw, o_symbol}, 0);
  endtask

  initial begin
    bit         ok;
    exp_t       none;
    logic [7:0] sf, bw, sym, chk, g;
    none = err_exp(3'd0);
    #1 rst_n = 1'b0;
    idle(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(2);

    run_frame(8'h07, 8'h01, 8'h5A, 8'h5C, ok);
    handshake(100, 1'b0);
    run_frame(8'h07, 8'h01, 8'h5A, 8'h5D, ok);
    run_frame(8'h04, 8'h00, 8'h00, 8'h04, ok);
    run_frame(8'h06, 8'h00, 8'h40, 8'h46, ok);

    // Timeout after SF byte; error lands T cycles after that byte is taken.
    send(8'hA5, 1'b0, none, 0);
    send(8'h07, 1'b1, err_exp(3'd3), 1 + T);
    m_code = 3'd3;
    idle(T + 5);
    check("timeout_code", o_err_code, 3);
    run_frame(8'h07, 8'h01, 8'h5A, 8'h5C, ok);
    handshake(10, 1'b0);

    send(8'h00, 1'b0, none, 0);
    send(8'hFF, 1'b0, none, 0);
    run_frame(8'h06, 8'h02, 8'h2B, 8'h2F, ok);
    handshake(20, 1'b1);

    // Framing errors: ignored in IDLE (byte discarded), reported mid-frame.
    send_rxerr(1'b0, 8'h00, 1'b0, none);
    send_rxerr(1'b1, 8'hA5, 1'b0, none);
    send(8'h07, 1'b0, none, 0);
    send(8'h01, 1'b0, none, 0);
    send(8'h5A, 1'b0, none, 0);
    send(8'h5C, 1'b0, none, 0);
    send(8'hA5, 1'b0, none, 0);
    send(8'h07, 1'b0, none, 0);
    send_rxerr(1'b1, 8'h01, 1'b1, err_exp(3'd4));
    m_code = 3'd4;
    idle(2);
    check("framing_code", o_err_code, 4);

    // Reset in GET_BW clears everything without an error.
    send(8'hA5, 1'b0, none, 0);
    send(8'h07, 1'b0, none, 0);
    rst_n = 1'b0;
    idle(1);
    check_all_zero("midframe_reset");
    m_sf = 0; m_bw = 0; m_sym = 0; m_code = 0;
    rst_n = 1'b1;
    idle(1);
    run_frame(8'h08, 8'h03, 8'hC3, 8'h08 ^ 8'h03 ^ 8'hC3, ok);
    handshake(5, 1'b0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h00;
        send(g, 1'b0, none, 0);
      end
      sf  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(5, 8)) : 8'($urandom_range(0, 15));
      bw  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      sym = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1 && sf <= 8) sym = 8'(int'(sym) % (1 << sf));
      chk = sf ^ bw ^ sym;
      if ($urandom_range(0, 4) == 0) chk = chk ^ 8'(1 << $urandom_range(0, 7));
      run_frame(sf, bw, sym, chk, ok);
      if (ok) handshake($urandom_range(1, 30), $urandom_range(0, 3) == 0);
      else idle($urandom_range(0, 2));
    end

    idle(5);
    check("scoreboard_drained", q.size(), 0);
    check("final_err_code", o_err_code, m_code);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
